// File: rtl/y86_fetch_decode_execute.sv
// Sequential Y86-64 fetch, decode/register-file and execute stage with internal instruction memory.
// Optional macro REG_WRITE_BYPASS_EN forwards same-cycle writeback values onto valA/valB.
module y86_fetch_decode_execute #(
  parameter int IMEM_BYTES = 1024,
  parameter int IMEM_AW    = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [63:0]        PC,
  input  logic               imem_we,
  input  logic [IMEM_AW-1:0] imem_waddr,
  input  logic [7:0]         imem_wdata,
  input  logic               wr_en,
  input  logic [63:0]        valM,
  output logic [3:0]         icode,
  output logic [3:0]         ifun,
  output logic [3:0]         rA,
  output logic [3:0]         rB,
  output logic [63:0]        valC,
  output logic [63:0]        valP,
  output logic [63:0]        valA,
  output logic [63:0]        valB,
  output logic [63:0]        valE,
  output logic               cnd,
  output logic               SF,
  output logic               ZF,
  output logic               OF,
  output logic               halt,
  output logic               nop,
  output logic               imem_error,
  output logic               func_error,
  output logic               reg_error
);

  localparam logic [63:0] IMEM_LIMIT = 64'(IMEM_BYTES);
  localparam logic [3:0]  RNONE   = 4'hF;
  localparam logic [3:0]  I_HALT  = 4'h0;
  localparam logic [3:0]  I_NOP   = 4'h1;
  localparam logic [3:0]  I_RRMOV = 4'h2;
  localparam logic [3:0]  I_IRMOV = 4'h3;
  localparam logic [3:0]  I_RMMOV = 4'h4;
  localparam logic [3:0]  I_MRMOV = 4'h5;
  localparam logic [3:0]  I_OP    = 4'h6;
  localparam logic [3:0]  I_JXX   = 4'h7;
  localparam logic [3:0]  I_CALL  = 4'h8;
  localparam logic [3:0]  I_RET   = 4'h9;
  localparam logic [3:0]  I_PUSH  = 4'hA;
  localparam logic [3:0]  I_POP   = 4'hB;

  logic [7:0]  r_imem [0:IMEM_BYTES-1];
  logic [63:0] r_regs [0:14];
  logic        r_sf, r_zf, r_of;

  logic [7:0]  w_byte [0:9];
  logic        w_need_regids, w_need_valc, w_imem_err;
  logic [3:0]  w_len;
  logic [63:0] w_room;
  logic [3:0]  w_src_a, w_src_b, w_dst_e, w_dst_m;
  logic [63:0] w_rd_a, w_rd_b;
  logic [63:0] w_alu_res;
  logic        w_new_of, w_cond, w_err, w_wr, w_cc_we;

  // Out-of-range bytes read as zero; the range check below flags them separately.
  function automatic logic [7:0] rd_byte(input logic [63:0] a);
    if (a < IMEM_LIMIT) rd_byte = r_imem[a[IMEM_AW-1:0]];
    else                rd_byte = 8'h00;
  endfunction

  // Ten-byte fetch window starting at PC
  always_comb begin
    for (int k = 0; k < 10; k++) w_byte[k] = rd_byte(PC + 64'(k));
  end

  // Instruction length from the raw opcode
  always_comb begin
    w_need_regids = 1'b0;
    w_need_valc   = 1'b0;
    case (w_byte[0][7:4])
      I_RRMOV, I_OP, I_PUSH, I_POP: w_need_regids = 1'b1;
      I_IRMOV, I_RMMOV, I_MRMOV: begin w_need_regids = 1'b1; w_need_valc = 1'b1; end
      I_JXX, I_CALL:                w_need_valc   = 1'b1;
      default:                      w_need_regids = 1'b0;
    endcase
  end

  assign w_len      = 4'd1 + {3'b000, w_need_regids} + (w_need_valc ? 4'd8 : 4'd0);
  assign w_room     = IMEM_LIMIT - 64'd1 - PC;
  assign w_imem_err = (PC >= IMEM_LIMIT) || (w_room < 64'(w_len - 4'd1));
  assign imem_error = w_imem_err;

  // Field split; an imem fault turns the instruction into a nop
  always_comb begin
    icode = I_NOP;
    ifun  = 4'h0;
    rA    = RNONE;
    rB    = RNONE;
    valC  = 64'd0;
    valP  = PC;
    if (!w_imem_err) begin
      icode = w_byte[0][7:4];
      ifun  = w_byte[0][3:0];
      valP  = PC + 64'(w_len);
      if (w_need_regids) begin
        rA = w_byte[1][7:4];
        rB = w_byte[1][3:0];
      end else begin
        rA = RNONE;
      end
      if (w_need_valc && w_need_regids)
        valC = {w_byte[9], w_byte[8], w_byte[7], w_byte[6], w_byte[5], w_byte[4], w_byte[3], w_byte[2]};
      else if (w_need_valc)
        valC = {w_byte[8], w_byte[7], w_byte[6], w_byte[5], w_byte[4], w_byte[3], w_byte[2], w_byte[1]};
      else
        valC = 64'd0;
    end else begin
      valP = PC;
    end
  end

  // Function-code and register-field validity
  always_comb begin
    func_error = 1'b0;
    reg_error  = 1'b0;
    case (icode)
      I_RRMOV, I_JXX:             func_error = (ifun > 4'd6);
      I_OP:                       func_error = (ifun > 4'd3);
      4'hC, 4'hD, 4'hE, 4'hF:     func_error = 1'b1;
      default:                    func_error = (ifun != 4'd0);
    endcase
    case (icode)
      I_RRMOV, I_RMMOV, I_MRMOV, I_OP: reg_error = (rA == RNONE) || (rB == RNONE);
      I_IRMOV:                         reg_error = (rB == RNONE);
      I_PUSH, I_POP:                   reg_error = (rA == RNONE);
      default:                         reg_error = 1'b0;
    endcase
  end

  assign halt    = (icode == I_HALT);
  assign nop     = (icode == I_NOP);
  assign w_err   = w_imem_err | func_error | reg_error;
  assign w_wr    = wr_en & ~w_err;
  assign w_cc_we = w_wr && (icode == I_OP);

  // Condition evaluation from the stored CC
  always_comb begin
    case (ifun)
      4'd0:    w_cond = 1'b1;
      4'd1:    w_cond = (r_sf ^ r_of) | r_zf;
      4'd2:    w_cond = r_sf ^ r_of;
      4'd3:    w_cond = r_zf;
      4'd4:    w_cond = ~r_zf;
      4'd5:    w_cond = ~(r_sf ^ r_of);
      4'd6:    w_cond = ~(r_sf ^ r_of) & ~r_zf;
      default: w_cond = 1'b0;
    endcase
    if (icode == I_RRMOV || icode == I_JXX) cnd = w_cond;
    else                                    cnd = 1'b0;
  end

  // Register sources and writeback destinations
  always_comb begin
    case (icode)
      I_RRMOV, I_RMMOV, I_OP, I_PUSH: w_src_a = rA;
      I_RET, I_POP:                   w_src_a = 4'd4;
      default:                        w_src_a = RNONE;
    endcase
    case (icode)
      I_RMMOV, I_MRMOV, I_OP:         w_src_b = rB;
      I_CALL, I_RET, I_PUSH, I_POP:   w_src_b = 4'd4;
      default:                        w_src_b = RNONE;
    endcase
    case (icode)
      I_RRMOV:                        w_dst_e = cnd ? rB : RNONE;
      I_IRMOV, I_OP:                  w_dst_e = rB;
      I_CALL, I_RET, I_PUSH, I_POP:   w_dst_e = 4'd4;
      default:                        w_dst_e = RNONE;
    endcase
    case (icode)
      I_MRMOV, I_POP:                 w_dst_m = rA;
      default:                        w_dst_m = RNONE;
    endcase
  end

  assign w_rd_a = (w_src_a == RNONE) ? 64'd0 : r_regs[w_src_a];
  assign w_rd_b = (w_src_b == RNONE) ? 64'd0 : r_regs[w_src_b];

  // ALU and next-flag computation; the ALU always sees stored register values
  always_comb begin
    w_alu_res = 64'd0;
    w_new_of  = 1'b0;
    case (icode)
      I_RRMOV:               w_alu_res = w_rd_a;
      I_IRMOV:               w_alu_res = valC;
      I_RMMOV, I_MRMOV:      w_alu_res = w_rd_b + valC;
      I_CALL, I_PUSH:        w_alu_res = w_rd_b - 64'd8;
      I_RET, I_POP:          w_alu_res = w_rd_b + 64'd8;
      I_OP: begin
        case (ifun)
          4'd0: begin
            w_alu_res = w_rd_b + w_rd_a;
            w_new_of  = (w_rd_a[63] == w_rd_b[63]) && (w_alu_res[63] != w_rd_a[63]);
          end
          4'd1: begin
            w_alu_res = w_rd_b - w_rd_a;
            w_new_of  = (w_rd_b[63] != w_rd_a[63]) && (w_alu_res[63] != w_rd_b[63]);
          end
          4'd2:    w_alu_res = w_rd_b & w_rd_a;
          4'd3:    w_alu_res = w_rd_b ^ w_rd_a;
          default: w_alu_res = 64'd0;
        endcase
      end
      default:               w_alu_res = 64'd0;
    endcase
  end

  assign valE = w_alu_res;
  assign SF   = r_sf;
  assign ZF   = r_zf;
  assign OF   = r_of;

`ifdef REG_WRITE_BYPASS_EN
  // Forward this cycle's writeback onto the read ports, dstM first
  always_comb begin
    if (w_wr && w_src_a != RNONE && w_src_a == w_dst_m)      valA = valM;
    else if (w_wr && w_src_a != RNONE && w_src_a == w_dst_e) valA = valE;
    else                                                     valA = w_rd_a;
    if (w_wr && w_src_b != RNONE && w_src_b == w_dst_m)      valB = valM;
    else if (w_wr && w_src_b != RNONE && w_src_b == w_dst_e) valB = valE;
    else                                                     valB = w_rd_b;
  end
`else
  assign valA = w_rd_a;
  assign valB = w_rd_b;
`endif

  // Program load; memory contents survive reset
  always_ff @(posedge clk) begin
    if (imem_we) r_imem[imem_waddr] <= imem_wdata;
  end

  // Register file and condition codes; valM is written last so it wins a dstE/dstM tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 15; i++) r_regs[i] <= 64'd0;
      r_sf <= 1'b0;
      r_zf <= 1'b0;
      r_of <= 1'b0;
    end else begin
      if (w_wr && w_dst_e != RNONE) r_regs[w_dst_e] <= valE;
      if (w_wr && w_dst_m != RNONE) r_regs[w_dst_m] <= valM;
      if (w_cc_we) begin
        r_sf <= w_alu_res[63];
        r_zf <= (w_alu_res == 64'd0);
        r_of <= w_new_of;
      end
    end
  end

endmodule

// File: tb/tb_y86_fetch_decode_execute.sv
// Directed scoreboard bench for y86_fetch_decode_execute (default build, bypass disabled).
module tb_y86_fetch_decode_execute;

  logic        clk, rst_n, imem_we, wr_en;
  logic [63:0] PC, valM;
  logic [9:0]  imem_waddr;
  logic [7:0]  imem_wdata;
  logic [3:0]  icode, ifun, rA, rB;
  logic [63:0] valC, valP, valA, valB, valE;
  logic        cnd, SF, ZF, OF, halt, nop, imem_error, func_error, reg_error;

  y86_fetch_decode_execute #(.IMEM_BYTES(1024), .IMEM_AW(10)) dut (
    .clk(clk), .rst_n(rst_n), .PC(PC), .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .wr_en(wr_en), .valM(valM), .icode(icode), .ifun(ifun),
    .rA(rA), .rB(rB), .valC(valC), .valP(valP), .valA(valA), .valB(valB), .valE(valE),
    .cnd(cnd), .SF(SF), .ZF(ZF), .OF(OF), .halt(halt), .nop(nop),
    .imem_error(imem_error), .func_error(func_error), .reg_error(reg_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  logic [63:0] rv;

  task automatic push_exp(input string tag, input logic [63:0] e);
    exp_t x;
    x.tag = tag;
    x.exp = e;
    exp_q.push_back(x);
  endtask

  task automatic chk(input logic [63:0] obs);
    exp_t x;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %h with no expected value", obs);
    end else begin
      x = exp_q.pop_front();
      assert (obs === x.exp) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", x.tag, obs, x.exp);
      end
    end
  endtask

  // Bytes are taken from the MSB end of data, first byte at addr.
  task automatic load_bytes(input int addr, input int n, input logic [79:0] data);
    for (int i = 0; i < n; i++) begin
      imem_we    = 1'b1;
      imem_waddr = 10'(addr + i);
      imem_wdata = data[79-8*i -: 8];
      @(posedge clk); #1;
    end
    imem_we = 1'b0;
  endtask

  task automatic step_wr(input logic [63:0] vm);
    wr_en = 1'b1;
    valM  = vm;
    @(posedge clk); #1;
    wr_en = 1'b0;
    valM  = 64'd0;
  endtask

  task automatic irmov(input int addr, input logic [3:0] r, input logic [63:0] v);
    logic [79:0] d;
    d[79:72] = 8'h30;
    d[71:64] = {4'hF, r};
    for (int i = 0; i < 8; i++) d[63-8*i -: 8] = v[8*i +: 8];
    load_bytes(addr, 10, d);
    PC = 64'(addr);
    #1;
    step_wr(64'd0);
  endtask

  task automatic read_reg(input logic [3:0] r, output logic [63:0] v);
    load_bytes(900, 2, {8'h20, r, 4'h0, 64'h0});
    PC = 64'd900;
    #1;
    v = valA;
  endtask

  initial begin
    rst_n = 1'b0; PC = 64'd0; imem_we = 1'b0; imem_waddr = 10'd0; imem_wdata = 8'h00;
    wr_en = 1'b0; valM = 64'd0;
    #12;
    push_exp("rst_SF", 64'd0); push_exp("rst_ZF", 64'd0); push_exp("rst_OF", 64'd0);
    chk(64'(SF)); chk(64'(ZF)); chk(64'(OF));
    rst_n = 1'b1;

    // 1: irmovq $5, %r0
    load_bytes(0, 10, 80'h30F0_0500_0000_0000_0000);
    push_exp("t1_icode", 64'd3); push_exp("t1_ifun", 64'd0); push_exp("t1_rA", 64'hF);
    push_exp("t1_rB", 64'd0); push_exp("t1_valC", 64'd5); push_exp("t1_valP", 64'd10);
    push_exp("t1_valE", 64'd5); push_exp("t1_errs", 64'd0);
    PC = 64'd0; #1;
    chk(64'(icode)); chk(64'(ifun)); chk(64'(rA)); chk(64'(rB)); chk(valC); chk(valP);
    chk(valE); chk(64'({imem_error, func_error, reg_error}));
    step_wr(64'd0);
    push_exp("t1_r0", 64'd5);
    read_reg(4'd0, rv); chk(rv);

    // 2: addq %r0,%r3 with r3=-5, then cmovle / cmovl
    irmov(20, 4'd3, 64'hFFFF_FFFF_FFFF_FFFB);
    load_bytes(40, 2, {16'h6003, 64'h0});
    push_exp("t2_add_valA", 64'd5); push_exp("t2_add_valB", 64'hFFFF_FFFF_FFFF_FFFB);
    push_exp("t2_add_valE", 64'd0);
    PC = 64'd40; #1;
    chk(valA); chk(valB); chk(valE);
    step_wr(64'd0);
    push_exp("t2_ZF", 64'd1); push_exp("t2_SF", 64'd0); push_exp("t2_OF", 64'd0);
    chk(64'(ZF)); chk(64'(SF)); chk(64'(OF));
    load_bytes(50, 2, {16'h2101, 64'h0});
    push_exp("t2_cmovle_cnd", 64'd1); push_exp("t2_cmovle_valE", 64'd5);
    PC = 64'd50; #1;
    chk(64'(cnd)); chk(valE);
    step_wr(64'd0);
    load_bytes(60, 2, {16'h2231, 64'h0});
    push_exp("t2_cmovl_cnd", 64'd0);
    PC = 64'd60; #1;
    chk(64'(cnd));
    step_wr(64'd0);
    push_exp("t2_r1_kept", 64'd5);
    read_reg(4'd1, rv); chk(rv);

    // 3: subq overflow, then and/xor and jumps on the new flags
    irmov(70, 4'd1, 64'd1);
    irmov(80, 4'd2, 64'h8000_0000_0000_0000);
    load_bytes(90, 2, {16'h6112, 64'h0});
    push_exp("t3_sub_valE", 64'h7FFF_FFFF_FFFF_FFFF);
    PC = 64'd90; #1;
    chk(valE);
    step_wr(64'd0);
    push_exp("t3_OF", 64'd1); push_exp("t3_SF", 64'd0); push_exp("t3_ZF", 64'd0);
    chk(64'(OF)); chk(64'(SF)); chk(64'(ZF));
    load_bytes(100, 2, {16'h6212, 64'h0});
    load_bytes(102, 2, {16'h6312, 64'h0});
    push_exp("t3_and_valE", 64'd1); push_exp("t3_xor_valE", 64'h7FFF_FFFF_FFFF_FFFE);
    PC = 64'd100; #1; chk(valE);
    PC = 64'd102; #1; chk(valE);
    load_bytes(110, 9, {8'h72, 72'h0});
    load_bytes(120, 9, {8'h76, 72'h0});
    load_bytes(130, 9, {8'h73, 72'h0});
    push_exp("t3_jl_cnd", 64'd1); push_exp("t3_jl_valP", 64'd119);
    push_exp("t3_jg_cnd", 64'd0); push_exp("t3_je_cnd", 64'd0);
    PC = 64'd110; #1; chk(64'(cnd)); chk(valP);
    PC = 64'd120; #1; chk(64'(cnd));
    PC = 64'd130; #1; chk(64'(cnd));

    // 4: instruction-memory boundary
    push_exp("t4_oob_err", 64'd1); push_exp("t4_oob_icode", 64'd1);
    push_exp("t4_oob_valP", 64'd1024); push_exp("t4_oob_rA", 64'hF);
    PC = 64'd1024; #1;
    chk(64'(imem_error)); chk(64'(icode)); chk(valP); chk(64'(rA));
    load_bytes(1014, 10, 80'h30F5_0700_0000_0000_0000);
    push_exp("t4_fit_err", 64'd0); push_exp("t4_fit_valP", 64'd1024); push_exp("t4_fit_valC", 64'd7);
    PC = 64'd1014; #1;
    chk(64'(imem_error)); chk(valP); chk(valC);
    load_bytes(1020, 2, {16'h30F0, 64'h0});
    load_bytes(1023, 1, {8'h10, 72'h0});
    push_exp("t4_cut_err", 64'd1); push_exp("t4_cut_valP", 64'd1020);
    push_exp("t4_last_err", 64'd0); push_exp("t4_last_valP", 64'd1024);
    PC = 64'd1020; #1; chk(64'(imem_error)); chk(valP);
    PC = 64'd1023; #1; chk(64'(imem_error)); chk(valP);

    // 5: function/register errors and halt
    load_bytes(200, 1, {8'hC0, 72'h0});
    load_bytes(202, 2, {16'h6401, 64'h0});
    load_bytes(204, 1, {8'h00, 72'h0});
    load_bytes(210, 10, 80'h30FF_0900_0000_0000_0000);
    load_bytes(230, 2, {16'h60F0, 64'h0});
    push_exp("t5_C0_func", 64'd1); push_exp("t5_64_func", 64'd1);
    push_exp("t5_halt", 64'd1); push_exp("t5_halt_valP", 64'd205); push_exp("t5_halt_func", 64'd0);
    push_exp("t5_irmov_regerr", 64'd1); push_exp("t5_addq_regerr", 64'd1);
    PC = 64'd200; #1; chk(64'(func_error));
    PC = 64'd202; #1; chk(64'(func_error));
    PC = 64'd204; #1; chk(64'(halt)); chk(valP); chk(64'(func_error));
    PC = 64'd210; #1; chk(64'(reg_error));
    PC = 64'd230; #1; chk(64'(reg_error));
    step_wr(64'd0);
    push_exp("t5_OF_kept", 64'd1); push_exp("t5_r0_kept", 64'd5);
    chk(64'(OF));
    read_reg(4'd0, rv); chk(rv);

    // 6: pushq, popq %rsp tie, asynchronous reset
    irmov(310, 4'd4, 64'h100);
    load_bytes(300, 2, {16'hA00F, 64'h0});
    push_exp("t6_push_valA", 64'd5); push_exp("t6_push_valB", 64'h100); push_exp("t6_push_valE", 64'hF8);
    PC = 64'd300; #1;
    chk(valA); chk(valB); chk(valE);
    step_wr(64'd0);
    push_exp("t6_r4_push", 64'hF8);
    read_reg(4'd4, rv); chk(rv);
    load_bytes(320, 2, {16'hB04F, 64'h0});
    push_exp("t6_pop_valE", 64'h100);
    PC = 64'd320; #1; chk(valE);
    step_wr(64'h1234);
    push_exp("t6_r4_pop_valM", 64'h1234);
    read_reg(4'd4, rv); chk(rv);
    PC = 64'd300;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    push_exp("t6_rst_OF", 64'd0); push_exp("t6_rst_r4", 64'd0); push_exp("t6_rst_push_valE", 64'hFFFF_FFFF_FFFF_FFF8);
    chk(64'(OF)); chk(valB); chk(valE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/y86_fetch_decode_execute.md
Name: y86_fetch_decode_execute

Overview:
Combined fetch, decode/register-file and execute stage of the sequential Y86-64 processor.
- The PC is supplied externally. The block reads the instruction bytes from an internal byte-wide instruction memory and splits them into fields.
- It reads the 15-entry register file and computes valE in the ALU.
- It holds the condition codes and evaluates the branch/cmov condition.
- Writeback to the register file happens on the clock edge when wr_en is set.

Parameters:
IMEM_BYTES, 1024, instruction memory size in bytes; valid addresses are 0..IMEM_BYTES-1.
IMEM_AW, 10, instruction-memory load address width.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
PC  in  64  fetch address
imem_we  in  1  instruction-memory byte write enable (program load)
imem_waddr  in  IMEM_AW  load address
imem_wdata  in  8  load byte
wr_en  in  1  register writeback and condition-code update enable
valM  in  64  memory result, written to dstM
icode, ifun  out  4 each  instruction code and function
rA, rB  out  4 each  register specifiers (F = none)
valC  out  64  constant, little-endian
valP  out  64  next sequential PC
valA, valB  out  64  register read values
valE  out  64  ALU result
cnd  out  1  condition result
SF, ZF, OF  out  1 each  condition-code register
halt, nop  out  1 each  icode==0 / icode==1
imem_error, func_error, reg_error  out  1 each  error flags

Behaviour:
Reset (rst_n low, asynchronous):
- All registers r0..r14 and SF/ZF/OF cleared to 0.
- Instruction memory contents are not reset.

Program load:
- Byte write on the rising clk edge when imem_we=1.

Fetch (combinational from PC):
- byte0 gives icode[7:4] and ifun[3:0].
- need_regids for icodes 2,3,4,5,6,A,B: byte1 gives rA[7:4] and rB[3:0].
- need_valC for icodes 3,4,5,7,8: 8 bytes, little-endian, following the opcode or register byte.
- valP = PC + 1 + need_regids + 8*need_valC.
- Unused fields: rA=rB=F, valC=0.

Fetch errors:
- imem_error = 1 if any byte the instruction needs lies at an address >= IMEM_BYTES.
- On imem_error: icode=1, ifun=0, rA=rB=F, valC=0, valP=PC.
- func_error = 1 if icode>B, or ifun is invalid: nonzero ifun outside icodes 2/6/7, ifun>6 for icodes 2/7, or ifun>3 for icode 6.

Decode:
- srcA = rA for icodes 2,4,6,A; 4 (%rsp) for icodes 9,B; otherwise F.
- srcB = rB for icodes 4,5,6; 4 for icodes 8,9,A,B; otherwise F.
- Register F reads as 0.
- reg_error = 1 when a required register field equals F: rA for icodes 2,4,5,6,A,B; rB for icodes 2,3,4,5,6.

Execute:
- icode 2: valA
- icode 3: valC
- icodes 4,5: valB+valC
- icode 6: valB OP valA with ifun 0 add, 1 sub (valB-valA), 2 and, 3 xor
- icodes 8,A: valB-8
- icodes 9,B: valB+8
- all others: 0
- All arithmetic is modulo 2^64.

Flags:
- New SF = result[63]; new ZF = (result==0).
- Add: OF = (a[63]==b[63]) && (result[63]!=a[63]).
- Sub: OF = (valB[63]!=valA[63]) && (result[63]!=valB[63]).
- and/xor: OF = 0.
- The CC register loads the new flags on the rising edge when icode=6, wr_en=1 and there is no error.

cnd (from the CC register):
- ifun 0: 1
- ifun 1 (le): (SF^OF)|ZF
- ifun 2 (l): SF^OF
- ifun 3 (e): ZF
- ifun 4 (ne): !ZF
- ifun 5 (ge): !(SF^OF)
- ifun 6 (g): !(SF^OF)&!ZF
- cnd is meaningful for icodes 2 and 7; it is 0 otherwise.

Writeback (rising edge, wr_en=1, no error):
- dstE = rB for icode 2 (only if cnd), icode 3 and icode 6; 4 for icodes 8,9,A,B.
- dstM = rA for icodes 5,B.
- valE is written to dstE and valM to dstM.
- If dstE==dstM, valM wins.
- F is never written.

Optional Feature:
REG_WRITE_BYPASS_EN:
- Defined: valA/valB forward the value being written this cycle when wr_en=1 and the source matches dstE/dstM. Priority is dstM, then dstE.
- Undefined: valA/valB return the stored register contents only.

Test Plan:
1. Reset, then load 30 F0 05 00 00 00 00 00 00 00 at address 0, PC=0 -> icode=3, ifun=0, rA=F, rB=0, valC=5, valP=10, valE=5; one edge with wr_en=1 -> r0=5.
2. r0=5, r3=-5 (via irmovq), then load 60 03 with wr_en=1 -> valE=0; after the edge ZF=1, SF=0, OF=0; then cmovle 21 01 -> cnd=1, valE=5.
3. r1=1, r2=0x8000000000000000, subq 61 12 -> valE=0x7FFFFFFFFFFFFFFF; after the edge OF=1, SF=0, ZF=0.
4. PC=1024 -> imem_error=1, icode=1, valP=1024; irmovq placed at PC=1020 -> imem_error=1.
5. Byte C0 -> func_error=1; byte 64 -> func_error=1; byte 00 -> halt=1, valP=PC+1; 30 FF ... -> reg_error=1 and no write occurs.
6. r4=0x100, pushq A0 0F -> valA=r0, valE=0xF8; after the edge r4=0xF8; asserting rst_n low mid-run clears r4 and CC immediately.
